muxn_pipe: RTL and testbench

//  Parametrised N-channel registered multiplexer. It is the successor to the 2:1 combinational mux.

---
 rtl/muxn_pipe.sv | 62 ++++++
 tb/tb_muxn_pipe.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/muxn_pipe.sv
// muxn_pipe: N-channel registered mux with per-channel valid/ready, external-select or round-robin grant
module muxn_pipe #(
  parameter int d_width   = 12,
  parameter int n_ch      = 4,
  parameter int sel_width = 2,
  parameter int mux_mode  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [d_width*n_ch-1:0] muxn_data,
  input  logic [n_ch-1:0]         muxn_valid,
  output logic [n_ch-1:0]         muxn_ready,
  input  logic [sel_width-1:0]    muxn_sel,
  output logic [d_width-1:0]      muxn_result,
  output logic                    muxn_rvalid,
  input  logic                    muxn_rready,
  output logic [sel_width-1:0]    muxn_rch,
  output logic                    muxn_selerr
);
  logic load, sel_ok, rr_hit, gnt_ok, xfer;
  logic [sel_width-1:0] last, rr_ch, gnt_ch;
  logic [d_width-1:0] gnt_data;
  int best;
  assign load   = rst_n & (~muxn_rvalid | muxn_rready);
  assign sel_ok = int'(muxn_sel) < n_ch;
  always_comb begin
    rr_hit = 1'b0;
    rr_ch  = '0;
    best   = n_ch;
    for (int c = 0; c < n_ch; c++)
      if (muxn_valid[c] && (c + 2*n_ch - 1 - int'(last)) % n_ch < best) begin
        rr_hit = 1'b1;
        rr_ch  = sel_width'(c);
        best   = (c + 2*n_ch - 1 - int'(last)) % n_ch;
      end
  end
  assign gnt_ok     = (mux_mode != 0) ? rr_hit : sel_ok;
  assign gnt_ch     = (mux_mode != 0) ? rr_ch : muxn_sel;
  assign muxn_ready = (load & gnt_ok) ? n_ch'(1) << gnt_ch : '0;
  assign xfer       = |(muxn_valid & muxn_ready);
  always_comb begin
    gnt_data = '0;
    for (int c = 0; c < n_ch; c++)
      gnt_data = muxn_ready[c] ? muxn_data[c*d_width +: d_width] : gnt_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      muxn_rvalid <= 1'b0;
      muxn_result <= '0;
      muxn_rch    <= '0;
      muxn_selerr <= 1'b0;
      last        <= sel_width'(n_ch - 1);
    end else begin
      muxn_selerr <= (mux_mode == 0) & load & ~sel_ok;
      if (load) muxn_rvalid <= xfer;
      if (xfer) begin
        muxn_result <= gnt_data;
        muxn_rch    <= gnt_ch;
        last        <= gnt_ch;
      end
    end
endmodule

// File: tb/tb_muxn_pipe.sv
// tb_muxn_pipe: randomized and directed checks of muxn_pipe against a behavioural model
module tb_muxn_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [47:0] data = '0;
  logic [3:0] valid = '0;
  logic [1:0] sel = '0;
  logic rready = 1'b0;
  logic [3:0] rdy0, rdy1;
  logic [2:0] rdy2;
  logic [2:0][11:0] res;
  logic [2:0] rv, err;
  logic [2:0][1:0] rch;
  int vectors = 0;
  int errors = 0;
  int nn[3] = '{4, 4, 3};
  int md[3] = '{0, 1, 0};
  int m_rv[3], m_res[3], m_rch[3], m_err[3], m_last[3];
  always #5 clk = ~clk;
  muxn_pipe #(.d_width(12), .n_ch(4), .sel_width(2), .mux_mode(0)) u_sel (
    .clk(clk), .rst_n(rst_n), .muxn_data(data), .muxn_valid(valid), .muxn_ready(rdy0),
    .muxn_sel(sel), .muxn_result(res[0]), .muxn_rvalid(rv[0]), .muxn_rready(rready),
    .muxn_rch(rch[0]), .muxn_selerr(err[0]));
  muxn_pipe #(.d_width(12), .n_ch(4), .sel_width(2), .mux_mode(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .muxn_data(data), .muxn_valid(valid), .muxn_ready(rdy1),
    .muxn_sel(sel), .muxn_result(res[1]), .muxn_rvalid(rv[1]), .muxn_rready(rready),
    .muxn_rch(rch[1]), .muxn_selerr(err[1]));
  muxn_pipe #(.d_width(12), .n_ch(3), .sel_width(2), .mux_mode(0)) u_n3 (
    .clk(clk), .rst_n(rst_n), .muxn_data(data[35:0]), .muxn_valid(valid[2:0]), .muxn_ready(rdy2),
    .muxn_sel(sel), .muxn_result(res[2]), .muxn_rvalid(rv[2]), .muxn_rready(rready),
    .muxn_rch(rch[2]), .muxn_selerr(err[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [47:0] pack(input logic [11:0] a, b, c, e);
    return {e, c, b, a};
  endfunction
  function automatic logic [3:0] ready_of(input int id);
    return id == 0 ? rdy0 : id == 1 ? rdy1 : {1'b0, rdy2};
  endfunction
  function automatic int grant(input int id);
    int c;
    if (md[id] == 0) return int'(sel) < nn[id] ? int'(sel) : -1;
    for (int k = 1; k <= nn[id]; k++) begin
      c = (m_last[id] + k) % nn[id];
      if (valid[c[1:0]]) return c;
    end
    return -1;
  endfunction
  task automatic model_reset();
    for (int id = 0; id < 3; id++) begin
      m_rv[id] = 0; m_res[id] = 0; m_rch[id] = 0; m_err[id] = 0; m_last[id] = nn[id] - 1;
    end
  endtask
  task automatic check_outputs();
    for (int id = 0; id < 3; id++) begin
      chk($sformatf("rvalid%0d", id), 32'(rv[id]), 32'(m_rv[id]));
      chk($sformatf("result%0d", id), 32'(res[id]), 32'(m_res[id]));
      chk($sformatf("rch%0d", id), 32'(rch[id]), 32'(m_rch[id]));
      chk($sformatf("selerr%0d", id), 32'(err[id]), 32'(m_err[id]));
    end
  endtask
  task automatic cycle(input logic [47:0] d, input logic [3:0] v, input logic [1:0] s, input logic rr);
    int g[3];
    int nrv[3], nres[3], nrch[3], nerr[3], nlast[3];
    bit load, x;
    data = d; valid = v; sel = s; rready = rr;
    #1;
    for (int id = 0; id < 3; id++) begin
      load = rst_n && (m_rv[id] == 0 || rr);
      g[id] = grant(id);
      chk($sformatf("ready%0d", id), 32'(ready_of(id)), (load && g[id] >= 0) ? 32'(1) << g[id] : 32'(0));
      nrv[id] = m_rv[id]; nres[id] = m_res[id]; nrch[id] = m_rch[id]; nlast[id] = m_last[id];
      nerr[id] = (md[id] == 0 && load && int'(s) >= nn[id]) ? 1 : 0;
      if (load) begin
        x = g[id] >= 0 && v[g[id][1:0]];
        nrv[id] = x ? 1 : 0;
        if (x) begin
          nres[id] = int'(d[g[id]*12 +: 12]);
          nrch[id] = g[id];
          nlast[id] = g[id];
        end
      end
    end
    @(posedge clk);
    for (int id = 0; id < 3; id++) begin
      m_rv[id] = nrv[id]; m_res[id] = nres[id]; m_rch[id] = nrch[id]; m_err[id] = nerr[id]; m_last[id] = nlast[id];
    end
    @(negedge clk);
    check_outputs();
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int id = 0; id < 3; id++) begin
      chk($sformatf("async_rvalid%0d", id), 32'(rv[id]), 32'(0));
      chk($sformatf("async_result%0d", id), 32'(res[id]), 32'(0));
      chk($sformatf("rst_ready%0d", id), 32'(ready_of(id)), 32'(0));
    end
    @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++) chk($sformatf("rst_ready_held%0d", id), 32'(ready_of(id)), 32'(0));
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    for (int id = 0; id < 3; id++) chk($sformatf("init_ready%0d", id), 32'(ready_of(id)), 32'(0));
    rst_n = 1'b1;
    cycle(pack(12'h0, 12'h0, 12'hABC, 12'h0), 4'b0100, 2'd2, 1'b1);
    chk("t2_result", 32'(res[0]), 32'h0ABC);
    chk("t2_rch", 32'(rch[0]), 32'd2);
    chk("t2_rvalid", 32'(rv[0]), 32'd1);
    cycle(pack(12'h111, 12'h0, 12'h0, 12'h0), 4'b0001, 2'd0, 1'b1);
    repeat (3) begin
      cycle(pack(12'h222, 12'h333, 12'h444, 12'h555), 4'b1111, 2'd1, 1'b0);
      chk("t3_stall_result", 32'(res[0]), 32'h111);
    end
    cycle(pack(12'h222, 12'h333, 12'h444, 12'h555), 4'b1111, 2'd1, 1'b1);
    chk("t3_release_result", 32'(res[0]), 32'h333);
    data = pack(12'h666, 12'h777, 12'h888, 12'h999); valid = 4'b1111; rready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle({16'($urandom), $urandom}, 4'b1111, 2'($urandom), 1'b1);
      chk("t4_rch", 32'(rch[1]), 32'(i % 4));
      chk("t4_rvalid", 32'(rv[1]), 32'd1);
    end
    cycle({16'($urandom), $urandom}, 4'b0010, 2'd0, 1'b1);
    chk("t5_first", 32'(rch[1]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle({16'($urandom), $urandom}, 4'b1010, 2'd0, 1'b1);
      chk("t5_rch", 32'(rch[1]), (i % 2 == 0) ? 32'd3 : 32'd1);
    end
    cycle({16'($urandom), $urandom}, 4'b0111, 2'd3, 1'b1);
    chk("t6_selerr", 32'(err[2]), 32'd1);
    chk("t6_rvalid", 32'(rv[2]), 32'd0);
    cycle({16'($urandom), $urandom}, 4'b0111, 2'd0, 1'b1);
    chk("t6_selerr_clear", 32'(err[2]), 32'd0);
    chk("t6_rvalid_back", 32'(rv[2]), 32'd1);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle({16'($urandom), $urandom}, 4'($urandom), 2'($urandom), $urandom_range(0, 3) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
